// File: rtl/serial_link_delay_ctrl.sv
// Serial-link latency controller: holds each beat for a programmable number of cycles, strict FIFO order.
// Optional handshake counter on beat_cnt_o is built when SERIAL_LINK_DELAY_CTRL_STATS_EN is defined.
module serial_link_delay_ctrl #(
    parameter int unsigned DataWidth = 8,
    parameter type         data_t    = logic [DataWidth-1:0],
    parameter int unsigned MaxDelay  = 16,
    parameter int unsigned Depth     = MaxDelay,
    parameter int unsigned DlyW      = $clog2(MaxDelay + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [DlyW-1:0] delay_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  data_t           data_i,
    output logic            valid_o,
    input  logic            ready_i,
    output data_t           data_o,
    output logic [15:0]     beat_cnt_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [DlyW-1:0] MaxDly   = DlyW'(MaxDelay);
    localparam logic [PtrW-1:0] LastSlot = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt  = CntW'(Depth);

    logic [Depth-1:0] vld;
    data_t            mem [Depth];
    logic [DlyW-1:0]  rem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count;
    logic             push;
    logic             pop;
    logic [DlyW-1:0]  delay_eff;

    // Both ports use plain valid/ready: a beat transfers on a clock edge where
    // valid and ready are both high; valid_o/data_o stay stable until that edge.
    assign ready_o   = (count != FullCnt);
    assign valid_o   = vld[rd_ptr] && (rem[rd_ptr] <= DlyW'(1));
    assign data_o    = mem[rd_ptr];
    assign push      = valid_i && ready_o;
    assign pop       = valid_o && ready_i;
    assign delay_eff = (delay_i > MaxDly) ? MaxDly : delay_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= (rd_ptr == LastSlot) ? '0 : rd_ptr + PtrW'(1);
            end
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= (wr_ptr == LastSlot) ? '0 : wr_ptr + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload and countdown need no reset; the valid bits gate their meaning.
    // A slot being written is never valid, so the write always wins over aging.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < Depth; i++) begin
            if (vld[i] && (rem[i] != '0)) begin
                rem[i] <= rem[i] - DlyW'(1);
            end
        end
        if (push) begin
            mem[wr_ptr] <= data_i;
            rem[wr_ptr] <= delay_eff;
        end
    end

`ifdef SERIAL_LINK_DELAY_CTRL_STATS_EN
    logic [15:0] beat_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= beat_cnt + 16'd1;
        end
    end

    assign beat_cnt_o = beat_cnt;
`else
    assign beat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_serial_link_delay_ctrl.sv
// Directed bench for serial_link_delay_ctrl (defaults: DataWidth 8, MaxDelay 16, Depth 16).
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_serial_link_delay_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  delay_i;
    logic        valid_i;
    logic        ready_o;
    logic [7:0]  data_i;
    logic        valid_o;
    logic        ready_i;
    logic [7:0]  data_o;
    logic [15:0] beat_cnt_o;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    serial_link_delay_ctrl dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .delay_i    (delay_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .beat_cnt_o (beat_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_beats(input int n);
`ifdef SERIAL_LINK_DELAY_CTRL_STATS_EN
        return 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    initial begin
        rst_i   = 1'b1;
        delay_i = '0;
        valid_i = 1'b0;
        data_i  = '0;
        ready_i = 1'b1;
        #1;
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_ready", 32'(ready_o), 1);
        chk("rst_beats", 32'(beat_cnt_o), 0);
        tick();
        rst_i = 1'b0;

        // Single beat, delay 5: low for 4 cycles, high on the 5th.
        delay_i = 5'd5; data_i = 8'hA5; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("single_wait", 32'(valid_o), 0);
            tick();
        end
        chk("single_valid", 32'(valid_o), 1);
        chk("single_data", 32'(data_o), 32'hA5);
        tick();
        chk("single_done", 32'(valid_o), 0);
        chk("single_beats", 32'(beat_cnt_o), exp_beats(1));

        // Zero delay is released one cycle after acceptance.
        delay_i = 5'd0; data_i = 8'h3C; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        chk("zero_valid", 32'(valid_o), 1);
        chk("zero_data", 32'(data_o), 32'h3C);
        tick();
        chk("zero_done", 32'(valid_o), 0);

        // Delay 31 saturates to 16.
        delay_i = 5'd31; data_i = 8'h5A; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            chk("sat_wait", 32'(valid_o), 0);
            tick();
        end
        chk("sat_valid", 32'(valid_o), 1);
        chk("sat_data", 32'(data_o), 32'h5A);
        tick();
        chk("sat_done", 32'(valid_o), 0);
        chk("sat_beats", 32'(beat_cnt_o), exp_beats(3));

        // Streaming: a beat occupies a slot from its push edge through its pop edge
        // with no fall-through, so delay 15 is the largest that streams into 16 slots.
        delay_i = 5'd15;
        for (int c = 0; c < 116; c++) begin
            valid_i = (c < 100);
            data_i  = 8'(c);
            if (c < 100) chk("stream_ready", 32'(ready_o), 1);
            tick();
            if (c >= 14 && c < 114) begin
                chk("stream_valid", 32'(valid_o), 1);
                chk("stream_data", 32'(data_o), 32'(c - 14));
            end else begin
                chk("stream_idle", 32'(valid_o), 0);
            end
        end
        valid_i = 1'b0;
        chk("stream_beats", 32'(beat_cnt_o), exp_beats(103));

        // Backpressure until full, stall with head held, then drain.
        ready_i = 1'b0; delay_i = 5'd2;
        for (int i = 0; i < 16; i++) begin
            valid_i = 1'b1;
            data_i  = 8'h80 + 8'(i);
            chk("fill_ready", 32'(ready_o), 1);
            tick();
        end
        data_i = 8'hEE;
        chk("full_ready", 32'(ready_o), 0);
        for (int k = 0; k < 3; k++) begin
            chk("stall_valid", 32'(valid_o), 1);
            chk("stall_data", 32'(data_o), 32'h80);
            chk("stall_ready", 32'(ready_o), 0);
            tick();
        end
        valid_i = 1'b0; ready_i = 1'b1;
        chk("full_pop_ready", 32'(ready_o), 0);
        chk("full_pop_data", 32'(data_o), 32'h80);
        tick();
        for (int i = 1; i < 16; i++) begin
            chk("drain_valid", 32'(valid_o), 1);
            chk("drain_data", 32'(data_o), 32'h80 + 32'(i));
            tick();
        end
        chk("drain_done", 32'(valid_o), 0);
        chk("drain_ready", 32'(ready_o), 1);
        chk("drain_beats", 32'(beat_cnt_o), exp_beats(119));

        // A (delay 8) then B (delay 1): B waits behind A.
        delay_i = 5'd8; data_i = 8'h11; valid_i = 1'b1;
        tick();
        chk("order_wait0", 32'(valid_o), 0);
        delay_i = 5'd1; data_i = 8'h22;
        tick();
        valid_i = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk("order_wait", 32'(valid_o), 0);
            tick();
        end
        chk("order_a_valid", 32'(valid_o), 1);
        chk("order_a_data", 32'(data_o), 32'h11);
        tick();
        chk("order_b_valid", 32'(valid_o), 1);
        chk("order_b_data", 32'(data_o), 32'h22);
        tick();
        chk("order_done", 32'(valid_o), 0);
        chk("order_beats", 32'(beat_cnt_o), exp_beats(121));

        // Reset mid-flight with three beats buffered.
        ready_i = 1'b0; delay_i = 5'd4;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            data_i  = 8'h60 + 8'(i);
            tick();
        end
        valid_i = 1'b0;
        tick();
        chk("flight_head", 32'(valid_o), 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_valid", 32'(valid_o), 0);
        chk("async_ready", 32'(ready_o), 1);
        chk("async_beats", 32'(beat_cnt_o), 0);
        #1;
        rst_i   = 1'b0;
        ready_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("no_stale", 32'(valid_o), 0);
        end
        chk("post_rst_ready", 32'(ready_o), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
